// File: rtl/reject_sampler_stream.sv
// rtl/reject_sampler_stream.sv - Kyber rejection sampler with in-order compaction buffer
// Filters candidate lanes against a latched threshold and streams accepted coefficients.
module reject_sampler_stream #(
  parameter int LANES     = 4,
  parameter int CAND_BITS = 12,
  parameter int OUT_LANES = 2,
  parameter int BUF_DEPTH = 8,
  parameter int TARGET    = 256,
  parameter int CNT_W     = 9
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           mode_select,
  input  logic [15:0]                    q,
  input  logic [15:0]                    bound,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES*CAND_BITS-1:0]     cand_bus,
  output logic [LANES-1:0]               acc_bus,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_LANES*CAND_BITS-1:0] out_data,
  output logic [CNT_W-1:0]               acc_count,
  output logic                           done
);

  localparam int FILL_W = $clog2(BUF_DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [15:0]          thr_q, thr_d;
  logic [LANES-1:0]     acc_q, acc_d;
  logic                 done_q, done_d;
  logic [CAND_BITS-1:0] buf_q [BUF_DEPTH];
  logic [CAND_BITS-1:0] buf_d [BUF_DEPTH];

  logic start_ok, push, pop;

  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign in_ready  = (state_q == S_RUN) && (fill_q <= FILL_W'(BUF_DEPTH - LANES));
  assign out_valid = (fill_q >= FILL_W'(OUT_LANES));
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign acc_bus   = acc_q;
  assign acc_count = cnt_q;
  assign done      = done_q;

  for (genvar k = 0; k < OUT_LANES; k++) begin : g_out
    assign out_data[k*CAND_BITS +: CAND_BITS] = buf_q[k];
  end

  always_comb begin
    int base;
    int n_keep;
    int rank;
    int remaining;
    logic [LANES-1:0] keep;

    base      = int'(fill_q) - (pop ? OUT_LANES : 0);
    remaining = TARGET - int'(cnt_q);
    n_keep    = 0;
    rank      = 0;
    keep      = '0;
    state_d   = state_q;
    thr_d     = thr_q;
    done_d    = done_q;

    // Lowest-index accepted lanes win when the polynomial is nearly full.
    for (int i = 0; i < LANES; i++) begin
      if (push && (16'(cand_bus[i*CAND_BITS +: CAND_BITS]) < thr_q) && (n_keep < remaining)) begin
        keep[i] = 1'b1;
        n_keep  = n_keep + 1;
      end
    end

    for (int j = 0; j < BUF_DEPTH; j++) begin
      buf_d[j] = buf_q[j];
    end
    if (pop) begin
      for (int j = 0; j < BUF_DEPTH - OUT_LANES; j++) begin
        buf_d[j] = buf_q[j + OUT_LANES];
      end
      for (int j = BUF_DEPTH - OUT_LANES; j < BUF_DEPTH; j++) begin
        buf_d[j] = '0;
      end
    end

    // Appends land just above the post-pop fill level, packed without gaps.
    for (int i = 0; i < LANES; i++) begin
      if (keep[i]) begin
        for (int j = 0; j < BUF_DEPTH; j++) begin
          if (base + rank == j) buf_d[j] = cand_bus[i*CAND_BITS +: CAND_BITS];
        end
        rank = rank + 1;
      end
    end

    fill_d = FILL_W'(base + n_keep);
    cnt_d  = cnt_q + CNT_W'(n_keep);
    acc_d  = push ? keep : acc_q;

    case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = S_RUN;
      S_RUN:          if (cnt_d == CNT_W'(TARGET)) state_d = S_DRAIN;
      S_DRAIN:        if (fill_q == '0) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase

    if (state_d == S_DONE && state_q != S_DONE) done_d = 1'b1;

    if (start_ok) begin
      cnt_d  = '0;
      fill_d = '0;
      done_d = 1'b0;
      thr_d  = mode_select ? bound : q;
      for (int j = 0; j < BUF_DEPTH; j++) buf_d[j] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fill_q  <= '0;
      cnt_q   <= '0;
      thr_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      for (int j = 0; j < BUF_DEPTH; j++) buf_q[j] <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      for (int j = 0; j < BUF_DEPTH; j++) buf_q[j] <= buf_d[j];
    end
  end

endmodule

// File: tb/tb_reject_sampler_stream.sv
// tb/tb_reject_sampler_stream.sv - directed vector bench for reject_sampler_stream
// Table of single-beat vectors plus hand-written backpressure, trim and reset sequences.
module tb_reject_sampler_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode_select = 1'b0;
  logic [15:0] q = 16'd3329;
  logic [15:0] bound = 16'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] cand_bus = '0;
  logic [3:0]  acc_bus;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_data;
  logic [8:0]  acc_count;
  logic        done;

  int tests = 0;
  int fails = 0;
  int beat_cnt = 0;
  logic [11:0] exp_q[$];

  reject_sampler_stream dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_select(mode_select),
    .q(q), .bound(bound), .in_valid(in_valid), .in_ready(in_ready),
    .cand_bus(cand_bus), .acc_bus(acc_bus), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .acc_count(acc_count), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [15:0] qv;
    logic [15:0] bv;
    logic [47:0] cands;
    logic [3:0]  acc;
    int          n;
    logic [47:0] outs;
  } vec_t;

  function automatic logic [47:0] pack(input int a, input int b, input int c, input int d);
    return {12'(d), 12'(c), 12'(b), 12'(a)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    start = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic do_start(input logic m, input logic [15:0] qv, input logic [15:0] bv);
    mode_select = m;
    q = qv;
    bound = bv;
    start = 1'b1;
    step();
    start = 1'b0;
    beat_cnt = 0;
  endtask

  task automatic send(input logic [47:0] bus);
    int n;
    n = 0;
    cand_bus = bus;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) chk("in_ready_wait", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [47:0] vals, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(vals[k*12 +: 12]);
  endtask

  // Output scoreboard: every popped beat must match the expected coefficient order.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      for (int k = 0; k < 2; k++) begin
        chk("out_have_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("out_data_lane", out_data[k*12 +: 12], exp_q.pop_front());
      end
      beat_cnt++;
    end
  end

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{1'b0, 16'd3329, 16'd0,    pack(5, 6, 7, 8),          4'b1111, 4, pack(5, 6, 7, 8)};
    vecs[1] = '{1'b0, 16'd3329, 16'd0,    pack(3328, 3329, 0, 4095), 4'b0101, 2, pack(3328, 0, 0, 0)};
    vecs[2] = '{1'b1, 16'd3329, 16'd17,   pack(16, 17, 18, 2),       4'b1001, 2, pack(16, 2, 0, 0)};
    vecs[3] = '{1'b0, 16'd3329, 16'd0,    pack(4095, 4000, 3330, 3329), 4'b0000, 0, pack(0, 0, 0, 0)};
    vecs[4] = '{1'b0, 16'd3329, 16'd0,    pack(1, 3329, 3328, 9),    4'b1101, 3, pack(1, 3328, 9, 0)};
    vecs[5] = '{1'b1, 16'd3329, 16'd0,    pack(0, 1, 2, 3),          4'b0000, 0, pack(0, 0, 0, 0)};
    vecs[6] = '{1'b1, 16'd0,    16'h1000, pack(4095, 0, 2048, 4094), 4'b1111, 4, pack(4095, 0, 2048, 4094)};
    vecs[7] = '{1'b0, 16'd1,    16'd0,    pack(0, 1, 0, 2),          4'b0101, 2, pack(0, 0, 0, 0)};

    do_reset();
    chk("reset_outputs", {in_ready, out_valid, done, acc_bus, acc_count, out_data}, '0);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      out_ready = 1'b1;
      do_start(vecs[v].mode, vecs[v].qv, vecs[v].bv);
      push_exp(vecs[v].outs, vecs[v].n);
      send(vecs[v].cands);
      chk($sformatf("vec%0d_acc_bus", v), acc_bus, vecs[v].acc);
      chk($sformatf("vec%0d_acc_count", v), acc_count, vecs[v].n);
      repeat (4) step();
      chk($sformatf("vec%0d_residue", v), exp_q.size(), vecs[v].n % 2);
      chk($sformatf("vec%0d_out_valid", v), out_valid, 0);
      chk($sformatf("vec%0d_in_ready", v), in_ready, 1);
    end

    // Threshold latched at start; mid-run input changes and restart attempts are ignored.
    do_reset();
    do_start(1'b1, 16'd3329, 16'd17);
    push_exp(pack(16, 2, 16, 2), 4);
    send(pack(16, 17, 18, 2));
    q = 16'd4095; bound = 16'd4095; mode_select = 1'b0;
    send(pack(16, 17, 18, 2));
    chk("latched_thr_acc_bus", acc_bus, 4'b1001);
    start = 1'b1; step(); start = 1'b0;
    chk("start_in_run_ignored", acc_count, 4);
    repeat (4) step();
    chk("latched_thr_drained", exp_q.size(), 0);

    // Backpressure: buffer fills to 8 and holds its head until downstream is ready.
    do_reset();
    out_ready = 1'b0;
    do_start(1'b0, 16'd3329, 16'd0);
    push_exp(pack(10, 11, 12, 13), 4);
    push_exp(pack(14, 15, 16, 17), 4);
    send(pack(10, 11, 12, 13));
    send(pack(14, 15, 16, 17));
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_head", out_data, {12'd11, 12'd10});
    cand_bus = pack(20, 21, 22, 23);
    in_valid = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    chk("bp_count_held", acc_count, 8);
    chk("bp_head_held", out_data, {12'd11, 12'd10});
    chk("bp_out_valid_held", out_valid, 1);
    out_ready = 1'b1;
    repeat (8) step();
    chk("bp_all_emitted", exp_q.size(), 0);
    chk("bp_beats", beat_cnt, 4);

    // Trim at the polynomial boundary, then drain to DONE.
    do_reset();
    out_ready = 1'b1;
    do_start(1'b0, 16'd3329, 16'd0);
    for (int b = 0; b < 63; b++) begin
      push_exp(pack(b*4, b*4+1, b*4+2, b*4+3), 4);
      send(pack(b*4, b*4+1, b*4+2, b*4+3));
    end
    push_exp(pack(100, 101, 0, 0), 2);
    send(pack(100, 4000, 101, 4000));
    chk("trim_pre_count", acc_count, 254);
    push_exp(pack(1, 2, 0, 0), 2);
    send(pack(1, 2, 3, 4));
    chk("trim_acc_bus", acc_bus, 4'b0011);
    chk("trim_acc_count", acc_count, 256);
    chk("trim_in_ready", in_ready, 0);
    n = 0;
    while (!done && n < 50) begin
      step();
      n++;
    end
    chk("trim_done", done, 1);
    repeat (3) step();
    chk("trim_beats", beat_cnt, 128);
    chk("trim_queue_empty", exp_q.size(), 0);
    chk("trim_count_sat", acc_count, 256);
    do_start(1'b0, 16'd3329, 16'd0);
    chk("restart_clears_done", {done, acc_count}, 0);

    // Asynchronous reset between edges with five coefficients buffered.
    do_reset();
    out_ready = 1'b0;
    do_start(1'b0, 16'd3329, 16'd0);
    send(pack(1, 2, 3, 4));
    send(pack(5, 4000, 4000, 4000));
    chk("ar_fill5_state", {out_valid, in_ready}, 2'b10);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_immediate", {out_valid, in_ready, done, acc_count}, '0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    do_start(1'b0, 16'd3329, 16'd0);
    push_exp(pack(7, 8, 9, 10), 4);
    send(pack(7, 8, 9, 10));
    repeat (4) step();
    chk("ar_resume_drained", exp_q.size(), 0);
    chk("ar_resume_count", acc_count, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reject_sampler_stream.md
Name: reject_sampler_stream

Overview:
- Next-generation Kyber rejection sampler.
- Takes LANES candidate words per beat and keeps only the ones that pass the threshold.
- Packs accepted coefficients, in order, into a compaction buffer and emits OUT_LANES coefficients per beat over a valid/ready stream.
- Stops after exactly TARGET coefficients per polynomial, adds backpressure and a programmable bound, and sits between the SHAKE/XOF squeeze path and NTT-domain polynomial RAM.

Parameters:
LANES, 4, candidates per input beat
CAND_BITS, 12, candidate width
OUT_LANES, 2, coefficients per output beat
BUF_DEPTH, 8, compaction buffer entries; must be >= LANES+OUT_LANES
TARGET, 256, coefficients per polynomial; must be a multiple of OUT_LANES
CNT_W, 9, width of the accepted counter; 2^CNT_W > TARGET

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a polynomial, honoured only in IDLE/DONE
mode_select  in  1  0: accept cand < q; 1: accept cand < bound
q  in  16  modulus (3329)
bound  in  16  alternate threshold
in_valid  in  1  candidate beat valid
in_ready  out  1  sampler can take a beat
cand_bus  in  LANES*CAND_BITS  candidates; lane i = bits [i*CAND_BITS +: CAND_BITS]
acc_bus  out  LANES  registered per-lane accept flags of the last handshaken beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
out_data  out  OUT_LANES*CAND_BITS  coefficients; lane 0 = oldest
acc_count  out  CNT_W  coefficients accepted so far
done  out  1  level; high once TARGET coefficients have been emitted

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, fill=0, acc_count=0, in_ready=0, out_valid=0, out_data=0, acc_bus=0, done=0.
- States:
  - IDLE: start -> RUN.
  - RUN: acc_count reaching TARGET -> DRAIN.
  - DRAIN: fill==0 -> DONE.
  - DONE: start -> RUN.
- On start:
  - acc_count, fill and done are cleared.
  - q, bound and mode_select are latched into the threshold register.
  - Changes to these inputs mid-run are ignored.
- Threshold: thr = mode ? bound : q. Lane i is accepted iff {4'b0, cand_i} < thr (unsigned, 16-bit compare).
- in_ready = (state==RUN) && (fill <= BUF_DEPTH-LANES). It is computed from registered fill only and never depends on out_ready.
- Input handshake (in_valid && in_ready):
  - Accepted lanes are appended at position fill in ascending lane order; rejected lanes leave no gap.
  - acc_bus is registered with the per-lane flags.
  - Trim: if acc_count + accepted > TARGET, only the lowest-index accepted lanes up to the remaining count are appended. The rest are dropped, and their acc_bus bits read 0.
- Output:
  - out_valid = (fill >= OUT_LANES).
  - out_data = entries 0..OUT_LANES-1, driven from registers.
  - On out_valid && out_ready the buffer shifts down by OUT_LANES.
- Simultaneous push and pop in one cycle:
  - fill_next = fill - OUT_LANES*pop + appended.
  - Appended entries land at position fill - OUT_LANES*pop.
- Latency: a coefficient accepted at edge N is visible on out_data from edge N+1 at the earliest.
- out_data/out_valid are held stable while out_valid && !out_ready.
- acc_count increments by the appended count at the handshake. It saturates exactly at TARGET and never exceeds it.
- Because TARGET % OUT_LANES == 0, DRAIN always empties fully with no partial beat.
- done: set on entering DONE, cleared by start.
- start while in RUN or DRAIN is ignored.
- in_valid with in_ready=0 has no effect and no acc_bus update.
- Mid-run reset: everything returns to reset values and buffered coefficients are discarded.

Test Plan:
- All-accept: cand lanes {5,6,7,8}, mode 0, q=3329, out_ready=1 -> acc_bus=4'hF; out beats (5,6) then (7,8); acc_count 0->4.
- Mixed reject: lanes {3328,3329,0,4095}, q=3329 -> acc_bus=4'b0101; out_data beat (3328,0); fill=0 afterwards.
- Bound mode: mode_select=1, bound=17, lanes {16,17,18,2} -> accept {16,2}. Then change q and bound mid-run -> the threshold stays 17.
- Backpressure: out_ready=0, feed all-accept beats -> in_ready drops after fill=8 (two beats). out_data is held constant; no data is lost after out_ready=1.
- Trim/terminate: TARGET=256, drive until acc_count=254, then an all-accept beat {1,2,3,4} -> only (1,2) are emitted; acc_bus=4'b0011, acc_count=256, in_ready=0. DRAIN -> DONE, done=1, and exactly 128 output beats in total.
- Async reset mid-RUN with fill=5: pull rst_n low between clock edges -> out_valid, in_ready, acc_count and done go to 0 immediately. A subsequent start resumes sampling correctly.
